// File: rtl/wb_req_arbiter.sv
// Writeback arbiter: three per-source FIFOs (cache=0, ALU=1, MUL=2) feeding the single ROB
// write port round-robin, with per-thread flush scrubbing and registered producer backpressure.

package wb_req_pkg;
   localparam int THR_PER_CORE       = 2;
   localparam int THR_PER_CORE_WIDTH = (THR_PER_CORE > 1) ? $clog2(THR_PER_CORE) : 1;

   typedef struct packed {
      logic [5:0]  rob_idx;
      logic [31:0] value;
      logic        exc;
   } writeback_request_t;
endpackage

module wb_src_fifo
   import wb_req_pkg::*;
#(
   parameter int FIFO_DEPTH = 2
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic [THR_PER_CORE-1:0]       flush_pipeline,
   input  logic                          req_valid,
   input  writeback_request_t            req_info,
   input  logic [THR_PER_CORE_WIDTH-1:0] req_thread_id,
   input  logic                          grant_pop,
   output logic                          ready,
   output logic                          head_cand,
   output writeback_request_t            head_info,
   output logic [THR_PER_CORE_WIDTH-1:0] head_thread_id,
   output logic                          any_valid
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   logic [FIFO_DEPTH-1:0]         vld_q, vld_d;
   writeback_request_t            info_q [FIFO_DEPTH];
   writeback_request_t            info_d [FIFO_DEPTH];
   logic [THR_PER_CORE_WIDTH-1:0] tid_q  [FIFO_DEPTH];
   logic [THR_PER_CORE_WIDTH-1:0] tid_d  [FIFO_DEPTH];
   logic [PW-1:0]                 rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]                 cnt_q, cnt_d;
   logic                          push, pop, scrub, head_vld;

   // Ready looks only at the registered count, never at this cycle's pop.
   assign ready          = reset && (cnt_q < CW'(FIFO_DEPTH));
   assign push           = req_valid && ready && !flush_pipeline[req_thread_id];
   assign head_vld       = (cnt_q != '0) && vld_q[rd_ptr_q];
   assign head_cand      = reset && head_vld && !flush_pipeline[tid_q[rd_ptr_q]];
   assign scrub          = (cnt_q != '0) && !vld_q[rd_ptr_q];
   assign pop            = scrub || grant_pop;
   assign head_info      = info_q[rd_ptr_q];
   assign head_thread_id = tid_q[rd_ptr_q];
   assign any_valid      = |vld_q;

   always_comb begin
      vld_d    = vld_q;
      info_d   = info_q;
      tid_d    = tid_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      cnt_d    = cnt_q;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         if (flush_pipeline[tid_q[i]]) vld_d[i] = 1'b0;
      end
      if (pop) begin
         vld_d[rd_ptr_q] = 1'b0;
         rd_ptr_d        = rd_ptr_q + PW'(1);
      end
      if (push) begin
         vld_d[wr_ptr_q]  = 1'b1;
         info_d[wr_ptr_q] = req_info;
         tid_d[wr_ptr_q]  = req_thread_id;
         wr_ptr_d         = wr_ptr_q + PW'(1);
      end
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         vld_q    <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         vld_q    <= vld_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Payload storage needs no reset: an entry is only read while its valid bit is set.
   always_ff @(posedge clock) begin
      info_q <= info_d;
      tid_q  <= tid_d;
   end

   a_no_push_when_full: assert property (@(posedge clock) disable iff (!reset)
      !(req_valid && !ready));
endmodule

module wb_req_arbiter
   import wb_req_pkg::*;
#(
   parameter int FIFO_DEPTH = 2
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic [THR_PER_CORE-1:0]       flush_pipeline,
   input  logic                          alu_req_valid,
   input  writeback_request_t            alu_req_info,
   input  logic [THR_PER_CORE_WIDTH-1:0] alu_thread_id,
   input  logic                          mul_req_valid,
   input  writeback_request_t            mul_req_info,
   input  logic [THR_PER_CORE_WIDTH-1:0] mul_thread_id,
   input  logic                          cache_req_valid,
   input  writeback_request_t            cache_req_info,
   input  logic [THR_PER_CORE_WIDTH-1:0] cache_thread_id,
   output logic                          alu_ready,
   output logic                          mul_ready,
   output logic                          cache_ready_o,
   output logic                          rob_req_valid,
   output writeback_request_t            rob_req_info,
   output logic [THR_PER_CORE_WIDTH-1:0] rob_req_thread_id,
   output logic [1:0]                    rob_req_src,
   input  logic                          rob_req_ready,
   output logic                          busy
);
   localparam int NSRC = 3;
   localparam int TW   = THR_PER_CORE_WIDTH;

   logic [NSRC-1:0]              src_req_valid, src_ready, head_cand, any_valid, grant_pop;
   writeback_request_t [NSRC-1:0] src_req_info, head_info;
   logic [NSRC-1:0][TW-1:0]      src_tid, head_tid;

   logic [1:0] rr_last_q, rr_last_d, src_q, src_d, lock_src_q, lock_src_d, grant;
   logic       lock_q, lock_d, grant_vld, accept;

   assign src_req_valid = {mul_req_valid, alu_req_valid, cache_req_valid};
   assign src_req_info  = {mul_req_info, alu_req_info, cache_req_info};
   assign src_tid       = {mul_thread_id, alu_thread_id, cache_thread_id};
   assign cache_ready_o = src_ready[0];
   assign alu_ready     = src_ready[1];
   assign mul_ready     = src_ready[2];

   for (genvar g = 0; g < NSRC; g++) begin : g_src
      wb_src_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
         .clock          (clock),
         .reset          (reset),
         .flush_pipeline (flush_pipeline),
         .req_valid      (src_req_valid[g]),
         .req_info       (src_req_info[g]),
         .req_thread_id  (src_tid[g]),
         .grant_pop      (grant_pop[g]),
         .ready          (src_ready[g]),
         .head_cand      (head_cand[g]),
         .head_info      (head_info[g]),
         .head_thread_id (head_tid[g]),
         .any_valid      (any_valid[g])
      );
   end

   function automatic logic [1:0] rr_idx(input logic [1:0] last, input int k);
      int s;
      s = (int'(last) + k) % NSRC;
      return 2'(s);
   endfunction

   // A stalled grant is locked so a newly arrived higher-priority source cannot
   // swap the payload under the ROB; only a flush of the locked head releases it.
   always_comb begin
      grant_vld = 1'b0;
      grant     = 2'd0;
      if (lock_q && head_cand[lock_src_q]) begin
         grant_vld = 1'b1;
         grant     = lock_src_q;
      end else begin
         for (int k = 1; k <= NSRC; k++) begin
            if (!grant_vld && head_cand[rr_idx(rr_last_q, k)]) begin
               grant_vld = 1'b1;
               grant     = rr_idx(rr_last_q, k);
            end
         end
      end
      accept     = grant_vld && rob_req_ready;
      grant_pop  = '0;
      if (accept) grant_pop[grant] = 1'b1;
      rr_last_d  = accept ? grant : rr_last_q;
      src_d      = grant_vld ? grant : src_q;
      lock_d     = grant_vld && !rob_req_ready;
      lock_src_d = grant;
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         rr_last_q  <= 2'd2;
         src_q      <= 2'd0;
         lock_q     <= 1'b0;
         lock_src_q <= 2'd0;
      end else begin
         rr_last_q  <= rr_last_d;
         src_q      <= src_d;
         lock_q     <= lock_d;
         lock_src_q <= lock_src_d;
      end
   end

   assign rob_req_valid     = grant_vld;
   assign rob_req_info      = grant_vld ? head_info[grant] : '0;
   assign rob_req_thread_id = grant_vld ? head_tid[grant] : '0;
   assign rob_req_src       = reset ? src_d : 2'd0;
   assign busy              = reset && (|any_valid);
endmodule

// File: tb/tb_wb_req_arbiter.sv
// Bench for wb_req_arbiter: per-cycle vector table for handshake/ready/busy outputs,
// plus a payload scoreboard fed at enqueue and drained at each ROB handshake.
module tb_wb_req_arbiter;
   import wb_req_pkg::*;
   localparam int TW = THR_PER_CORE_WIDTH;

   logic                  clock = 1'b0;
   logic                  reset = 1'b0;
   logic [THR_PER_CORE-1:0] flush_pipeline = '0;
   logic                  alu_req_valid = 1'b0, mul_req_valid = 1'b0, cache_req_valid = 1'b0;
   writeback_request_t    alu_req_info = '0, mul_req_info = '0, cache_req_info = '0;
   logic [TW-1:0]         alu_thread_id = '0, mul_thread_id = '0, cache_thread_id = '0;
   logic                  alu_ready, mul_ready, cache_ready_o;
   logic                  rob_req_valid;
   writeback_request_t    rob_req_info;
   logic [TW-1:0]         rob_req_thread_id;
   logic [1:0]            rob_req_src;
   logic                  rob_req_ready = 1'b0;
   logic                  busy;

   always #5 clock = ~clock;

   wb_req_arbiter #(.FIFO_DEPTH(2)) dut (
      .clock             (clock),
      .reset             (reset),
      .flush_pipeline    (flush_pipeline),
      .alu_req_valid     (alu_req_valid),
      .alu_req_info      (alu_req_info),
      .alu_thread_id     (alu_thread_id),
      .mul_req_valid     (mul_req_valid),
      .mul_req_info      (mul_req_info),
      .mul_thread_id     (mul_thread_id),
      .cache_req_valid   (cache_req_valid),
      .cache_req_info    (cache_req_info),
      .cache_thread_id   (cache_thread_id),
      .alu_ready         (alu_ready),
      .mul_ready         (mul_ready),
      .cache_ready_o     (cache_ready_o),
      .rob_req_valid     (rob_req_valid),
      .rob_req_info      (rob_req_info),
      .rob_req_thread_id (rob_req_thread_id),
      .rob_req_src       (rob_req_src),
      .rob_req_ready     (rob_req_ready),
      .busy              (busy)
   );

   // Source bit order in masks: [2]=MUL, [1]=ALU, [0]=cache.
   typedef struct {
      logic       rst_n;
      logic       rdy;
      logic [1:0] flush;
      logic [2:0] v;
      logic [2:0] tid;
      logic       exp_v;
      logic [1:0] exp_src;
      logic       exp_busy;
      logic [2:0] exp_rdy;
   } vec_t;

   typedef struct {
      logic [1:0]         src;
      logic [TW-1:0]      tid;
      writeback_request_t info;
   } sb_t;

   vec_t               tbl[$];
   sb_t                sb[$];
   int                 n_vec = 0, n_bad = 0, tag = 1, cyc = 0;
   logic               prev_hold = 1'b0;
   writeback_request_t prev_info;
   logic [1:0]         prev_src;
   logic [TW-1:0]      prev_tid;

   function automatic vec_t V(input logic rst_n, input logic rdy, input logic [1:0] fl,
                              input logic [2:0] v, input logic [2:0] tid, input logic ev,
                              input logic [1:0] es, input logic eb, input logic [2:0] er);
      vec_t r;
      r.rst_n = rst_n; r.rdy = rdy; r.flush = fl; r.v = v; r.tid = tid;
      r.exp_v = ev; r.exp_src = es; r.exp_busy = eb; r.exp_rdy = er;
      return r;
   endfunction

   function automatic writeback_request_t mkinfo(input int t);
      writeback_request_t r;
      r.rob_idx = 6'(t);
      r.value   = 32'hA500_0000 + 32'(t);
      r.exc     = t[0];
      return r;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
      end
   endtask

   task automatic step(input vec_t v);
      writeback_request_t inf [3];
      logic [TW-1:0]      tids[3];
      int                 idx;
      @(negedge clock);
      cyc++;
      for (int s = 0; s < 3; s++) begin
         inf[s]  = mkinfo(tag + s);
         tids[s] = TW'(v.tid[s]);
      end
      tag += 3;
      reset           = v.rst_n;
      rob_req_ready   = v.rdy;
      flush_pipeline  = v.flush;
      cache_req_valid = v.v[0]; cache_req_info = inf[0]; cache_thread_id = tids[0];
      alu_req_valid   = v.v[1]; alu_req_info   = inf[1]; alu_thread_id   = tids[1];
      mul_req_valid   = v.v[2]; mul_req_info   = inf[2]; mul_thread_id   = tids[2];
      #2;
      chk("rob_req_valid", 64'(rob_req_valid), 64'(v.exp_v));
      chk("rob_req_src", 64'(rob_req_src), 64'(v.exp_src));
      chk("busy", 64'(busy), 64'(v.exp_busy));
      chk("readies{mul,alu,cache}", 64'({mul_ready, alu_ready, cache_ready_o}), 64'(v.exp_rdy));
      if (prev_hold && v.rst_n && v.flush == 2'b00) begin
         chk("hold_valid", 64'(rob_req_valid), 64'(1));
         chk("hold_src", 64'(rob_req_src), 64'(prev_src));
         chk("hold_info", 64'(rob_req_info), 64'(prev_info));
         chk("hold_tid", 64'(rob_req_thread_id), 64'(prev_tid));
      end
      if (!v.rst_n) begin
         sb.delete();
      end else begin
         if (rob_req_valid && v.rdy) begin
            idx = -1;
            foreach (sb[j]) if (idx < 0 && sb[j].src == rob_req_src) idx = j;
            n_vec++;
            if (idx < 0) begin
               n_bad++;
               $display("FAIL sb_pop cycle %0d: handshake from src %0d, expected none queued",
                        cyc, rob_req_src);
            end else begin
               chk("rob_req_info", 64'(rob_req_info), 64'(sb[idx].info));
               chk("rob_req_thread_id", 64'(rob_req_thread_id), 64'(sb[idx].tid));
               sb.delete(idx);
            end
         end
         for (int j = sb.size() - 1; j >= 0; j--) if (v.flush[sb[j].tid]) sb.delete(j);
         for (int s = 0; s < 3; s++) begin
            if (v.v[s] && v.exp_rdy[s] && !v.flush[tids[s]]) begin
               sb_t e;
               e.src = 2'(s); e.tid = tids[s]; e.info = inf[s];
               sb.push_back(e);
            end
         end
      end
      prev_hold = rob_req_valid && !v.rdy && v.rst_n;
      prev_info = rob_req_info;
      prev_src  = rob_req_src;
      prev_tid  = rob_req_thread_id;
   endtask

   initial begin
      // reset then single ALU request
      tbl.push_back(V(0,1,2'b00,3'b000,3'b000, 0,2'd0,0,3'b000));
      tbl.push_back(V(0,1,2'b00,3'b000,3'b000, 0,2'd0,0,3'b000));
      tbl.push_back(V(1,1,2'b00,3'b010,3'b000, 0,2'd0,0,3'b111));
      tbl.push_back(V(1,1,2'b00,3'b000,3'b000, 1,2'd1,1,3'b111));
      tbl.push_back(V(1,1,2'b00,3'b000,3'b000, 0,2'd1,0,3'b111));
      // round-robin from reset: cache, ALU, MUL twice
      tbl.push_back(V(0,1,2'b00,3'b000,3'b000, 0,2'd0,0,3'b000));
      tbl.push_back(V(1,1,2'b00,3'b111,3'b000, 0,2'd0,0,3'b111));
      tbl.push_back(V(1,1,2'b00,3'b111,3'b000, 1,2'd0,1,3'b111));
      tbl.push_back(V(1,1,2'b00,3'b000,3'b000, 1,2'd1,1,3'b001));
      tbl.push_back(V(1,1,2'b00,3'b000,3'b000, 1,2'd2,1,3'b011));
      tbl.push_back(V(1,1,2'b00,3'b000,3'b000, 1,2'd0,1,3'b111));
      tbl.push_back(V(1,1,2'b00,3'b000,3'b000, 1,2'd1,1,3'b111));
      tbl.push_back(V(1,1,2'b00,3'b000,3'b000, 1,2'd2,1,3'b111));
      tbl.push_back(V(1,1,2'b00,3'b000,3'b000, 0,2'd2,0,3'b111));
      // backpressure: MUL fills, cache arrives mid-stall, MUL payload must stay
      tbl.push_back(V(1,0,2'b00,3'b100,3'b000, 0,2'd2,0,3'b111));
      tbl.push_back(V(1,0,2'b00,3'b100,3'b100, 1,2'd2,1,3'b111));
      tbl.push_back(V(1,0,2'b00,3'b000,3'b000, 1,2'd2,1,3'b011));
      tbl.push_back(V(1,0,2'b00,3'b001,3'b000, 1,2'd2,1,3'b011));
      tbl.push_back(V(1,0,2'b00,3'b000,3'b000, 1,2'd2,1,3'b011));
      tbl.push_back(V(1,0,2'b00,3'b000,3'b000, 1,2'd2,1,3'b011));
      tbl.push_back(V(1,1,2'b00,3'b000,3'b000, 1,2'd2,1,3'b011));
      tbl.push_back(V(1,1,2'b00,3'b000,3'b000, 1,2'd0,1,3'b111));
      tbl.push_back(V(1,1,2'b00,3'b000,3'b000, 1,2'd2,1,3'b111));
      tbl.push_back(V(1,1,2'b00,3'b000,3'b000, 0,2'd2,0,3'b111));
      // flush of presented head coincides with ready: flush wins, head scrubbed
      tbl.push_back(V(1,0,2'b00,3'b010,3'b000, 0,2'd2,0,3'b111));
      tbl.push_back(V(1,0,2'b00,3'b010,3'b010, 1,2'd1,1,3'b111));
      tbl.push_back(V(1,1,2'b01,3'b000,3'b000, 0,2'd1,1,3'b101));
      tbl.push_back(V(1,1,2'b00,3'b000,3'b000, 0,2'd1,1,3'b101));
      tbl.push_back(V(1,1,2'b00,3'b000,3'b000, 1,2'd1,1,3'b111));
      tbl.push_back(V(1,1,2'b00,3'b000,3'b000, 0,2'd1,0,3'b111));
      // enqueue during flush of its own thread is dropped
      tbl.push_back(V(1,1,2'b10,3'b001,3'b001, 0,2'd1,0,3'b111));
      tbl.push_back(V(1,1,2'b00,3'b000,3'b000, 0,2'd1,0,3'b111));
      // reset with four entries queued; cache must win first afterwards
      tbl.push_back(V(1,0,2'b00,3'b111,3'b001, 0,2'd1,0,3'b111));
      tbl.push_back(V(1,0,2'b00,3'b010,3'b010, 1,2'd2,1,3'b111));
      tbl.push_back(V(0,1,2'b00,3'b000,3'b000, 0,2'd0,0,3'b000));
      tbl.push_back(V(1,1,2'b00,3'b011,3'b000, 0,2'd0,0,3'b111));
      tbl.push_back(V(1,1,2'b00,3'b000,3'b000, 1,2'd0,1,3'b111));
      tbl.push_back(V(1,1,2'b00,3'b000,3'b000, 1,2'd1,1,3'b111));
      tbl.push_back(V(1,1,2'b00,3'b000,3'b000, 0,2'd1,0,3'b111));

      for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

      // streaming: ALU pushes and pops every cycle, pointers wrap, ready never drops
      for (int k = 0; k < 8; k++)
         step(V(1,1,2'b00,3'b010,3'b000, (k != 0),2'd1,(k != 0),3'b111));
      step(V(1,1,2'b00,3'b000,3'b000, 1,2'd1,1,3'b111));
      step(V(1,1,2'b00,3'b000,3'b000, 0,2'd1,0,3'b111));

      chk("scoreboard_drained", 64'(sb.size()), 64'(0));
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
